// File: rtl/interrupt_scheduler_pkg.sv
// Shared types for the channel interrupt scheduler.
// Four-phase batch sequencer state and default sizing.
package interrupt_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_CHNL = 12;

endpackage

// File: rtl/interrupt_scheduler.sv
// Coalesces per-channel events into batched interrupt requests
// and sequences the host read / controller done handshake.
module interrupt_scheduler
  import interrupt_scheduler_pkg::*;
#(
  parameter int unsigned C_NUM_CHNL  = DEF_NUM_CHNL,
  parameter int unsigned C_HOLDOFF   = 16,
  parameter int unsigned C_HOLDOFF_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [C_NUM_CHNL-1:0] CHNL_INTR,
  input  logic                  CONFIG_INTERRUPT_MSIENABLE,
  input  logic                  VECT_RD,
  output logic [C_NUM_CHNL-1:0] VECT_OUT,
  output logic                  INTR,
  output logic                  INTR_LEGACY_CLR,
  input  logic                  INTR_DONE,
  output logic                  BUSY
);

  localparam logic [C_HOLDOFF_W-1:0] HOLD_INIT =
    (C_HOLDOFF > 0) ? C_HOLDOFF_W'(C_HOLDOFF - 1) : '0;

  state_e                  state_q;
  logic [C_NUM_CHNL-1:0]   pend_q;
  logic [C_NUM_CHNL-1:0]   vect_q;
  logic [C_HOLDOFF_W-1:0]  cnt_q;
  logic                    intr_q;
  logic                    clr_q;
  logic                    mode_q;
  logic                    done_seen_q;
  logic                    read_seen_q;

  logic done_any;
  logic read_any;

  assign done_any = done_seen_q | INTR_DONE;
  assign read_any = read_seen_q | VECT_RD;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      vect_q      <= '0;
      cnt_q       <= '0;
      intr_q      <= 1'b0;
      clr_q       <= 1'b0;
      mode_q      <= 1'b0;
      done_seen_q <= 1'b0;
      read_seen_q <= 1'b0;
    end else begin
      intr_q <= 1'b0;
      pend_q <= pend_q | CHNL_INTR;
      unique case (state_q)
        ST_IDLE: begin
          clr_q <= 1'b0;
          if (|pend_q) begin
            if (C_HOLDOFF > 0) begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= HOLD_INIT;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_q <= ST_ISSUE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ISSUE: begin
          vect_q      <= pend_q | CHNL_INTR;
          pend_q      <= '0;
          mode_q      <= CONFIG_INTERRUPT_MSIENABLE;
          done_seen_q <= 1'b0;
          read_seen_q <= 1'b0;
          intr_q      <= 1'b1;
          clr_q       <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          done_seen_q <= done_any;
          read_seen_q <= read_any;
          // Legacy clear is a level: raised by the first read, dropped by done.
          clr_q <= !mode_q && !done_any &&
                   (clr_q || (VECT_RD && !read_seen_q));
          if (done_any && read_any) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign VECT_OUT        = vect_q;
  assign INTR            = intr_q;
  assign INTR_LEGACY_CLR = clr_q;
  assign BUSY            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Self-checking bench for interrupt_scheduler: directed table,
// hand sequences and a randomized run against a timeline model.
module tb_interrupt_scheduler;

  localparam int N = 12;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] chnl = '0;
  logic         msi = 1'b1;
  logic         vrd = 1'b0;
  logic         idone = 1'b0;
  logic [N-1:0] vect;
  logic         intr;
  logic         clr;
  logic         busy;

  interrupt_scheduler #(
    .C_NUM_CHNL (N),
    .C_HOLDOFF  (H),
    .C_HOLDOFF_W(8)
  ) dut (
    .CLK                       (clk),
    .RST_N                     (rst_n),
    .CHNL_INTR                 (chnl),
    .CONFIG_INTERRUPT_MSIENABLE(msi),
    .VECT_RD                   (vrd),
    .VECT_OUT                  (vect),
    .INTR                      (intr),
    .INTR_LEGACY_CLR           (clr),
    .INTR_DONE                 (idone),
    .BUSY                      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] ev;
    logic         rd;
    logic         dn;
    logic         e_intr;
    logic         e_clr;
    logic         e_busy;
    logic [N-1:0] e_vect;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] ev, input logic rd,
                      input logic dn);
    chnl  = ev;
    vrd   = rd;
    idone = dn;
    @(posedge clk);
    #1;
    chnl  = '0;
    vrd   = 1'b0;
    idone = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Random-phase model state
  logic [N-1:0] m_pend;
  logic [N-1:0] m_vect;
  int           phase;
  int           issue_cyc;
  bit           m_mode, m_ds, m_rs, m_clr, iss;
  logic [N-1:0] r_ev;
  logic         r_rd, r_dn;
  int           r;

  initial begin
    // Reset values
    #2;
    chk("rst_vect", 32'(vect), 0);
    chk("rst_intr", 32'(intr), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_busy", 32'(busy), 0);
    do_reset();

    // Single event, MSI: table of per-cycle vectors
    msi = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tv[i].ev     = '0;
      tv[i].rd     = 1'b0;
      tv[i].dn     = 1'b0;
      tv[i].e_intr = (i == 7);
      tv[i].e_clr  = 1'b0;
      tv[i].e_busy = (i >= 2 && i <= 20);
      tv[i].e_vect = (i >= 7) ? N'(12'h008) : '0;
    end
    tv[0].ev  = N'(12'h008);
    tv[12].dn = 1'b1;
    tv[20].rd = 1'b1;
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("t1_intr[%0d]", i), 32'(intr), 32'(tv[i].e_intr));
      chk($sformatf("t1_clr[%0d]", i), 32'(clr), 32'(tv[i].e_clr));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("t1_vect[%0d]", i), 32'(vect), 32'(tv[i].e_vect));
      step(tv[i].ev, tv[i].rd, tv[i].dn);
    end

    // Coalesce two channels into one batch
    step(N'(12'h001), 1'b0, 1'b0);
    run(2);
    step(N'(12'h020), 1'b0, 1'b0);
    run(3);
    chk("t2_intr", 32'(intr), 1);
    chk("t2_vect", 32'(vect), 32'h021);
    step('0, 1'b0, 1'b0);
    chk("t2_intr_once", 32'(intr), 0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_clr", 32'(clr), 0);

    // Event during WAIT starts a new batch
    step(N'(12'h002), 1'b0, 1'b0);
    run(6);
    chk("t3_intr1", 32'(intr), 1);
    step(N'(12'h004), 1'b0, 1'b0);
    chk("t3_vect_hold", 32'(vect), 32'h002);
    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0);
    chk("t3_idle", 32'(busy), 0);
    run(6);
    chk("t3_intr2", 32'(intr), 1);
    chk("t3_vect2", 32'(vect), 32'h004);
    step('0, 1'b1, 1'b1);
    chk("t3_idle2", 32'(busy), 0);

    // Legacy clear handshake
    msi = 1'b0;
    step(N'(12'h010), 1'b0, 1'b0);
    run(6);
    chk("t4_intr", 32'(intr), 1);
    chk("t4_clr0", 32'(clr), 0);
    step('0, 1'b1, 1'b0);
    chk("t4_clr1", 32'(clr), 1);
    step('0, 1'b0, 1'b0);
    chk("t4_clr_hold", 32'(clr), 1);
    chk("t4_busy", 32'(busy), 1);
    step('0, 1'b0, 1'b1);
    chk("t4_clr_off", 32'(clr), 0);
    chk("t4_idle", 32'(busy), 0);

    // Read / done while idle are ignored
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t6_busy", 32'(busy), 0);
      chk("t6_clr", 32'(clr), 0);
      chk("t6_intr", 32'(intr), 0);
      chk("t6_vect", 32'(vect), 32'h010);
      step('0, 1'b0, 1'b0);
    end

    // Reset in WAIT with legacy clear raised and pending bits in flight
    step(N'(12'h001), 1'b0, 1'b0);
    run(6);
    chk("t5_intr", 32'(intr), 1);
    step('0, 1'b1, 1'b0);
    chk("t5_clr", 32'(clr), 1);
    step(N'(12'h008), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_intr", 32'(intr), 0);
    chk("t5_rst_clr", 32'(clr), 0);
    chk("t5_rst_vect", 32'(vect), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("t5_no_intr", 32'(intr), 0);
      chk("t5_no_busy", 32'(busy), 0);
      step('0, 1'b0, 1'b0);
    end

    // Randomized run against a cycle-timeline model
    do_reset();
    m_pend = '0; m_vect = '0; phase = 0; issue_cyc = 0;
    m_mode = 0; m_ds = 0; m_rs = 0; m_clr = 0;
    for (int k = 0; k < 4000; k++) begin
      chk("rnd_intr", 32'(intr), 32'(phase == 2 && k == issue_cyc + 1));
      chk("rnd_busy", 32'(busy), 32'(phase != 0));
      chk("rnd_clr", 32'(clr), 32'(m_clr));
      chk("rnd_vect", 32'(vect), 32'(m_vect));
      r = $urandom_range(0, 9);
      if (r == 0) r_ev = N'($urandom);
      else if (r < 3) r_ev = N'(1) << $urandom_range(0, N - 1);
      else r_ev = '0;
      r_rd = ($urandom_range(0, 5) == 0);
      r_dn = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) msi = ~msi;
      iss = (phase == 1 && k == issue_cyc);
      if (phase == 0) begin
        if (m_pend != 0) begin
          phase = 1;
          issue_cyc = k + 1 + H;
        end
      end else if (iss) begin
        m_vect = m_pend | r_ev;
        m_mode = msi;
        m_ds = 0;
        m_rs = 0;
        phase = 2;
      end else if (phase == 2) begin
        if (!m_mode && r_rd && !m_rs && !(m_ds || r_dn)) m_clr = 1;
        if (r_dn) m_clr = 0;
        if ((m_ds || r_dn) && (m_rs || r_rd)) begin
          phase = 0;
          m_clr = 0;
        end
        m_ds = m_ds | r_dn;
        m_rs = m_rs | r_rd;
      end
      m_pend = iss ? '0 : (m_pend | r_ev);
      step(r_ev, r_rd, r_dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
